ctrl_divisor_frecuencia: RTL and testbench

Run/stop and rate-select controller for the board's clock-enable generator, clocked from the 100 MHz Nexys oscillator. Produces a registered square wave `Clock_o` and a one-cycle `tick_o` strobe at one of four programmable rates. Rate changes are requested through a req/ack handshake and take effect only on a half-period boundary, so `Clock_o` never produces a runt pulse. Consumers use `tick_o` as a clock enable; `Clock_o` drives external or visible signals only.

---
 rtl/ctrl_divisor_frecuencia.sv | 146 ++++++++++++++
 tb/tb_ctrl_divisor_frecuencia.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_divisor_frecuencia.sv
// Run/stop and rate-select controller: square wave Clock_o plus a one-cycle
// tick_o strobe at one of four rates; rate changes land on half-period edges.
module ctrl_divisor_frecuencia #(
  parameter int unsigned W    = 16,
  parameter int unsigned DIV0 = 49_999,
  parameter int unsigned DIV1 = 24_999,
  parameter int unsigned DIV2 = 4_999,
  parameter int unsigned DIV3 = 499
) (
  input  logic       Clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic [1:0] sel_i,
  input  logic       req_i,
  output logic       ack_o,
  output logic       busy_o,
  output logic       tick_o,
  output logic       Clock_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   contador_q, contador_d;
  logic [W-1:0]   limite_q, limite_d;
  logic [1:0]     sel_cur_q, sel_cur_d;
  logic [1:0]     sel_pend_q, sel_pend_d;
  logic           stop_pend_q, stop_pend_d;
  logic           clock_q, clock_d;
  logic           tick_q, tick_d;
  logic           ack_q, ack_d;
  logic           busy_q, busy_d;
  logic           tc;
  logic           stopping;

  function automatic logic [W-1:0] div_sel(input logic [1:0] s);
    logic [W-1:0] r;
    unique case (s)
      2'd0:    r = W'(DIV0);
      2'd1:    r = W'(DIV1);
      2'd2:    r = W'(DIV2);
      default: r = W'(DIV3);
    endcase
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    contador_d  = contador_q;
    limite_d    = limite_q;
    sel_cur_d   = sel_cur_q;
    sel_pend_d  = sel_pend_q;
    stop_pend_d = stop_pend_q;
    clock_d     = clock_q;
    ack_d       = 1'b0;

    tc       = (state_q != IDLE) && (contador_q == limite_q);
    // A stop only completes on the falling toggle, so a high phase is never cut short.
    stopping = tc && stop_pend_q && clock_q;

    unique case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          state_d    = RUN;
          limite_d   = div_sel(sel_i);
          sel_cur_d  = sel_i;
          contador_d = '0;
        end
      end
      RUN: begin
        if (req_i && (sel_i == sel_cur_q)) begin
          ack_d = 1'b1;
        end else if (req_i) begin
          sel_pend_d = sel_i;
          state_d    = PEND;
        end
      end
      PEND: begin
        if (tc) begin
          limite_d  = div_sel(sel_pend_q);
          sel_cur_d = sel_pend_q;
          ack_d     = 1'b1;
          state_d   = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      if (tc) begin
        contador_d = '0;
        clock_d    = ~clock_q;
      end else begin
        contador_d = contador_q + 1'b1;
      end
      if (stop_i) begin
        stop_pend_d = 1'b1;
      end
      if (stopping) begin
        state_d     = IDLE;
        stop_pend_d = 1'b0;
        contador_d  = '0;
      end
    end

    tick_d = tc;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      contador_q  <= '0;
      limite_q    <= W'(DIV0);
      sel_cur_q   <= 2'd0;
      sel_pend_q  <= 2'd0;
      stop_pend_q <= 1'b0;
      clock_q     <= 1'b0;
      tick_q      <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      contador_q  <= contador_d;
      limite_q    <= limite_d;
      sel_cur_q   <= sel_cur_d;
      sel_pend_q  <= sel_pend_d;
      stop_pend_q <= stop_pend_d;
      clock_q     <= clock_d;
      tick_q      <= tick_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
    end
  end

  assign Clock_o = clock_q;
  assign tick_o  = tick_q;
  assign ack_o   = ack_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_ctrl_divisor_frecuencia.sv
// Scoreboard bench for ctrl_divisor_frecuencia: a countdown-based model predicts
// tick/ack events and busy/Clock levels; a negedge monitor consumes them.
module tb_ctrl_divisor_frecuencia;

  localparam int W  = 16;
  localparam int D0 = 3;
  localparam int D1 = 1;
  localparam int D2 = 5;
  localparam int D3 = 9;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       req   = 1'b0;
  logic [1:0] sel   = 2'd0;
  logic       ack, busy, tick, clko;

  always #5 clk = ~clk;

  ctrl_divisor_frecuencia #(
    .W(W), .DIV0(D0), .DIV1(D1), .DIV2(D2), .DIV3(D3)
  ) dut (
    .Clock_i(clk),
    .reset_i(rst),
    .start_i(start),
    .stop_i(stop),
    .sel_i(sel),
    .req_i(req),
    .ack_o(ack),
    .busy_o(busy),
    .tick_o(tick),
    .Clock_o(clko)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int at; logic v;} ev_t;
  typedef struct {int at; logic busy; logic clk;} lvl_t;

  ev_t  exp_tick[$];
  ev_t  exp_ack[$];
  lvl_t exp_lvl[$];

  int n_cmp = 0;
  int n_err = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  // Model: running flag, time left to the next toggle, pending rate and stop request.
  bit m_run, m_pend, m_stop, m_clk;
  int m_cur, m_psel, m_half, m_rem;
  int divs[4] = '{D0, D1, D2, D3};

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_stop = 0; m_clk = 0;
    m_cur = 0; m_psel = 0; m_half = D0 + 1; m_rem = 0;
  endtask

  task automatic model(input bit st, input bit sp, input bit rq, input int s);
    bit tk = 0;
    bit ak = 0;
    bit np = 0;
    bit old_clk;
    int at = cyc + 1;
    if (!m_run) begin
      if (st && !sp) begin
        m_run = 1; m_cur = s; m_half = divs[s] + 1; m_rem = m_half;
      end
    end else begin
      np = !m_pend && rq && (s != m_cur);
      if (!m_pend && rq && (s == m_cur)) ak = 1;
      m_rem--;
      if (m_rem == 0) begin
        tk = 1;
        old_clk = m_clk;
        m_clk = !m_clk;
        if (m_pend) begin
          m_cur = m_psel; m_half = divs[m_psel] + 1; ak = 1; m_pend = 0;
        end
        m_rem = m_half;
        if (m_stop && old_clk) begin
          m_run = 0; m_stop = 0; np = 0;
        end
      end
      if (m_run) begin
        if (np) begin m_pend = 1; m_psel = s; end
        if (sp) m_stop = 1;
      end
    end
    if (tk) exp_tick.push_back(ev_t'{at, m_clk});
    if (ak) exp_ack.push_back(ev_t'{at, 1'b0});
    exp_lvl.push_back(lvl_t'{at, m_run, m_clk});
  endtask

  // Monitor: compares levels every cycle and pops events when the DUT strobes.
  always @(negedge clk) begin
    lvl_t l;
    ev_t  e;
    bit   here;
    if (exp_lvl.size() > 0 && exp_lvl[0].at <= cyc) begin
      l = exp_lvl.pop_front();
      check("lvl_cycle", l.at, cyc);
      check("busy_o", busy, l.busy);
      check("Clock_o", clko, l.clk);
    end
    here = (exp_tick.size() > 0) && (exp_tick[0].at == cyc);
    if (tick || here) begin
      check("tick_o", tick, here);
      if (here) begin
        e = exp_tick.pop_front();
        if (tick) check("tick_Clock_o", clko, e.v);
      end
    end
    here = (exp_ack.size() > 0) && (exp_ack[0].at == cyc);
    if (ack || here) begin
      check("ack_o", ack, here);
      if (here) e = exp_ack.pop_front();
    end
  end

  task automatic step(input bit st, input bit sp, input bit rq, input int s);
    @(negedge clk); #1;
    rst = 0; start = st; stop = sp; req = rq; sel = 2'(s);
    model(st, sp, rq, s);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1; start = 0; stop = 0; req = 0;
    #1;
    check("rst_tick_o", tick, 0);
    check("rst_ack_o", ack, 0);
    check("rst_busy_o", busy, 0);
    check("rst_Clock_o", clko, 0);
    model_reset();
    exp_lvl.push_back(lvl_t'{cyc + 1, 1'b0, 1'b0});
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // start at rate 0, watch a few periods
    step(1, 0, 0, 0);
    idle_cycles(20);
    // mid half-period change to rate 2
    idle_cycles(2);
    step(0, 0, 1, 2);
    idle_cycles(24);
    // equal-select request
    step(0, 0, 1, 2);
    idle_cycles(14);
    // move to rate 3, then stop while Clock_o is low
    step(0, 0, 1, 3);
    idle_cycles(25);
    for (int i = 0; i < 40 && m_clk != 0; i++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    idle_cycles(40);
    // pending change to rate 1 plus stop while high: reload, ack, stop together
    step(1, 0, 0, 3);
    for (int i = 0; i < 40 && !(m_clk == 1 && m_rem > 3); i++) step(0, 0, 0, 0);
    step(0, 0, 1, 1);
    step(0, 1, 0, 0);
    idle_cycles(30);
    step(1, 0, 0, 0);
    idle_cycles(20);
    // reset in PEND, then restart
    step(1, 0, 0, 3);
    idle_cycles(5);
    step(0, 0, 1, 0);
    idle_cycles(2);
    do_reset();
    step(1, 0, 0, 0);
    idle_cycles(20);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 15) == 0, $urandom_range(0, 59) == 0,
             $urandom_range(0, 7) == 0, int'($urandom_range(0, 3)));
      end
    end
    idle_cycles(1);

    repeat (3) @(negedge clk);
    #2;
    check("tick_left", exp_tick.size(), 0);
    check("ack_left", exp_ack.size(), 0);
    check("lvl_left", exp_lvl.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
